wfg_mem_arbiter: RTL
====================

// Module: wfg_mem_arbiter
// PURPOSE
//  Shares the single read port of the stimulus SRAM (csb1/addr1/dout1) between NREQ requesters,
//  e.g. the memory stimulus streamer and a Wishbone readback/debug path.
//  Round-robin arbitration, one read issued per cycle, fully pipelined.
//  Read data is returned in order and tagged to the requester that issued it.
//  Sits between the wfg_stim_mem/Wishbone logic and the top-level SRAM pins.
// PARAMETERS
//  NREQ    2   number of requesters (>=2)
//  AW      10  SRAM address width
//  DW      32  SRAM data width
//  RD_LAT  1   SRAM read latency in cycles: cycles from the edge capturing csb1=0/addr1 to dout1 valid (>=1)
// PORTS
//  wb_clk_i     in   1        clock
//  wb_rst_ni    in   1        reset, asynchronous, active-low
//  en_i         in   1        arbitration enable; 0 = no new grants
//  req_valid_i  in   NREQ     per-requester read request
//  req_addr_i   in   NREQ*AW  per-requester address, slice i = [i*AW +: AW]
//  req_ready_o  out  NREQ     one-hot grant; request accepted when valid&ready
//  rsp_valid_o  out  NREQ     one-hot, 1-cycle pulse: rsp_data_o is valid for that requester
//  rsp_data_o   out  DW       read data, shared by all requesters
//  busy_o       out  1        1 while any read is in flight
//  csb1         out  1        SRAM chip select, active-low, registered
//  addr1        out  AW       SRAM address, registered
//  dout1        in   DW       SRAM read data
// BEHAVIOUR
//  Reset values: csb1=1, addr1=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0. RR pointer=0.
//  req_ready_o is combinational: en_i && grant[i]. It is 0 while reset is asserted.
//  grant: one-hot, at most one bit set. Search starts at the RR pointer and picks the first i with req_valid_i[i].
//    grant=0 when no requester is valid.
//  Pointer update: on an accept by requester g, ptr <= (g+1) mod NREQ. The pointer holds otherwise.
//  Accept in cycle k: csb1=0, addr1=req_addr[g] during cycle k+1.
//    With no accept in cycle k, csb1=1 during cycle k+1 and addr1 holds its last value.
//  Tag pipeline: a valid bit plus a requester ID, shifted each cycle, depth RD_LAT+1.
//  At the tag output, rsp_data_o <= dout1 and rsp_valid_o[id] <= 1, both registered.
//  Latency: rsp_valid_o[g] is high exactly in cycle k+2+RD_LAT. Throughput: 1 read per cycle sustained.
//  rsp_data_o holds its last value when rsp_valid_o=0.
//  No response backpressure: requesters must accept rsp_valid_o whenever it pulses.
//  busy_o = OR of the tag-pipeline valid bits, plus the rsp_valid_o stage.
//  en_i falling: no new grants from that cycle. In-flight reads still complete and are delivered.
//  Requester valid drop before accept: allowed. The arbiter re-evaluates every cycle.
//    A request is only committed on valid&ready.
//  Simultaneous: all requesters valid every cycle -> strict rotation, each served once per NREQ cycles.
//  Pointer wrap: NREQ-1 -> 0.
//  Reset mid-operation: all pipeline stages are cleared asynchronously and in-flight responses are discarded.
//    No rsp_valid_o pulse is produced after reset release for reads issued before reset.
// STRUCTURE
//  Package wfg_mem_pkg: localparams for the SRAM AW/DW defaults, and typedef mem_tag_t {logic vld; logic [$clog2(NREQ)-1:0] id;}.
//  Sub-module wfg_rr_arbiter: NREQ-wide round-robin grant plus pointer; takes an advance input.
//  The top holds the SRAM output registers, the tag shift pipeline and the response register.
// TESTING
//  Single read: only req0 valid, addr=0x005, SRAM[5]=0xDEADBEEF
//    -> csb1=0/addr1=0x005 one cycle after accept; rsp_valid_o=2'b01, data=0xDEADBEEF at accept+3 (RD_LAT=1).
//  Contention: req0 and req1 held valid for 8 cycles with distinct addresses
//    -> grants alternate 0,1,0,1...; 8 responses in order, each to the correct requester with the correct data.
//  Back-to-back: req1 streams addresses 0..15 continuously
//    -> csb1 low for 16 consecutive cycles; 16 consecutive rsp_valid_o[1] pulses with data SRAM[0..15].
//  Enable gating: en_i=0 while req0 is valid -> req_ready_o=0 and csb1=1.
//    Drop en_i while 2 reads are in flight -> both responses are still delivered and busy_o falls afterwards.
//  Reset mid-flight: assert wb_rst_ni=0 one cycle after an accept
//    -> outputs go to reset values immediately; no rsp_valid_o pulse after release.
//  RD_LAT=2 build: repeat the single-read and contention cases
//    -> response at accept+4, ordering unchanged.

Source files
------------

// File: rtl/wfg_mem_pkg.sv
// rtl/wfg_mem_pkg.sv - SRAM width defaults and in-flight read tag type for the stimulus memory arbiter
package wfg_mem_pkg;

  localparam int MEM_AW   = 10;
  localparam int MEM_DW   = 32;
  // Requester-ID field width; wide enough for up to 16 requesters.
  localparam int MEM_ID_W = 4;

  typedef struct packed {
    logic                vld;
    logic [MEM_ID_W-1:0] id;
  } mem_tag_t;

endpackage

// File: rtl/wfg_rr_arbiter.sv
// rtl/wfg_rr_arbiter.sv - round-robin one-hot grant; pointer moves past the winner on advance
module wfg_rr_arbiter
  import wfg_mem_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_i,
  input  logic                advance_i,
  output logic [NREQ-1:0]     grant_o,
  output logic [MEM_ID_W-1:0] grant_id_o
);

  logic [MEM_ID_W-1:0] ptr_q, ptr_d;
  logic                any_req;

  assign any_req = |req_i;

  always_comb begin
    grant_id_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) grant_id_o = MEM_ID_W'(i);
    end
    // Requesters at or above the pointer outrank the wrapped-around ones.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i] && (MEM_ID_W'(i) >= ptr_q)) grant_id_o = MEM_ID_W'(i);
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = any_req && (grant_id_o == MEM_ID_W'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_id_o == MEM_ID_W'(NREQ - 1)) ? '0 : grant_id_o + MEM_ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wfg_mem_arbiter.sv
// rtl/wfg_mem_arbiter.sv - shares the stimulus SRAM read port between NREQ requesters, in-order tagged responses
module wfg_mem_arbiter
  import wfg_mem_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int AW     = MEM_AW,
  parameter int DW     = MEM_DW,
  parameter int RD_LAT = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 en_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [DW-1:0]        rsp_data_o,
  output logic                 busy_o,
  output logic                 csb1,
  output logic [AW-1:0]        addr1,
  input  logic [DW-1:0]        dout1
);

  logic [NREQ-1:0]     grant;
  logic [MEM_ID_W-1:0] grant_id;
  logic                accept;

  logic                csb1_q, csb1_d;
  logic [AW-1:0]       addr1_q, addr1_d;
  mem_tag_t [RD_LAT:0] tag_q, tag_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]       rsp_data_q, rsp_data_d;

  wfg_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_ni),
    .req_i      (req_valid_i),
    .advance_i  (accept),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign accept      = en_i && (|grant);
  assign req_ready_o = (en_i && wb_rst_ni) ? grant : '0;

  always_comb begin
    csb1_d  = !accept;
    addr1_d = addr1_q;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && grant[i]) addr1_d = req_addr_i[i*AW +: AW];
    end
  end

  // Stage 0 lines up with the SRAM cycle; stage RD_LAT lines up with valid dout1.
  always_comb begin
    tag_d[0].vld = accept;
    tag_d[0].id  = grant_id;
    for (int s = 1; s <= RD_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_q[RD_LAT].vld) begin
      rsp_data_d = dout1;
      for (int i = 0; i < NREQ; i++) begin
        if (tag_q[RD_LAT].id == MEM_ID_W'(i)) rsp_valid_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    busy_o = |rsp_valid_q;
    for (int s = 0; s <= RD_LAT; s++) begin
      busy_o = busy_o | tag_q[s].vld;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      csb1_q      <= 1'b1;
      addr1_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      csb1_q      <= csb1_d;
      addr1_q     <= addr1_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign csb1        = csb1_q;
  assign addr1       = addr1_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule
